// File: rtl/mul4_accum.sv
// Dot-product accumulator for the mul4 product stream: sums N_TERMS products per frame
// and presents each frame sum with a one-cycle valid pulse and a sticky overflow flag.
module mul4_accum #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             prod_valid,
    input  logic [7:0]       prod_in,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    output logic [3:0]       term_cnt,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(N_TERMS - 1);

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] accOut_q;
    logic [3:0]       termCnt_q;
    logic             ovfFlag_q;
    logic             ovfOut_q;
    logic             accValid_q;

    logic [ACC_W-1:0] prodExt_d;
    logic [ACC_W:0]   sum_d;
    logic             xfer_d;

    // The extra top bit of the sum is the carry out of the accumulator width.
    assign prodExt_d = ACC_W'(prod_in);
    assign sum_d     = {1'b0, acc_q} + {1'b0, prodExt_d};
    assign in_ready  = (state_q != DONE);
    assign xfer_d    = prod_valid && in_ready;

    assign acc_out   = accOut_q;
    assign acc_valid = accValid_q;
    assign term_cnt  = termCnt_q;
    assign ovf       = ovfOut_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            accOut_q   <= '0;
            termCnt_q  <= '0;
            ovfFlag_q  <= 1'b0;
            ovfOut_q   <= 1'b0;
            accValid_q <= 1'b0;
        end else if (clear) begin
            // Abort the frame; the last completed result stays visible.
            state_q    <= IDLE;
            acc_q      <= '0;
            termCnt_q  <= '0;
            ovfFlag_q  <= 1'b0;
            accValid_q <= 1'b0;
        end else begin
            accValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (xfer_d) begin
                        acc_q     <= prodExt_d;
                        termCnt_q <= 4'd1;
                        ovfFlag_q <= 1'b0;
                        if (N_TERMS == 1) begin
                            state_q    <= DONE;
                            accOut_q   <= prodExt_d;
                            ovfOut_q   <= 1'b0;
                            accValid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer_d) begin
                        acc_q     <= sum_d[ACC_W-1:0];
                        termCnt_q <= termCnt_q + 4'd1;
                        ovfFlag_q <= ovfFlag_q | sum_d[ACC_W];
                        if (termCnt_q == LAST_IDX) begin
                            state_q    <= DONE;
                            accOut_q   <= sum_d[ACC_W-1:0];
                            ovfOut_q   <= ovfFlag_q | sum_d[ACC_W];
                            accValid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    termCnt_q <= '0;
                end
                default: begin
                    state_q   <= IDLE;
                    termCnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul4_accum.sv
// Directed bench for mul4_accum: hand-computed frames, gaps, back-to-back, clear and async reset.
// A second instance with ACC_W=8 shares the stimulus to exercise wrap and overflow.
module tb_mul4_accum;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       prod_valid;
    logic [7:0] prod_in;

    logic       in_ready;
    logic [9:0] acc_out;
    logic       acc_valid;
    logic [3:0] term_cnt;
    logic       ovf;

    logic       in_ready8;
    logic [7:0] acc_out8;
    logic       acc_valid8;
    logic [3:0] term_cnt8;
    logic       ovf8;

    int testsRun;
    int testsFailed;

    mul4_accum #(.N_TERMS(4), .ACC_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .prod_valid(prod_valid),
        .prod_in   (prod_in),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .term_cnt  (term_cnt),
        .ovf       (ovf)
    );

    mul4_accum #(.N_TERMS(4), .ACC_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .prod_valid(prod_valid),
        .prod_in   (prod_in),
        .in_ready  (in_ready8),
        .acc_out   (acc_out8),
        .acc_valid (acc_valid8),
        .term_cnt  (term_cnt8),
        .ovf       (ovf8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one cycle of inputs and returns just after the edge that consumed them.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c);
        prod_valid = v;
        prod_in    = d;
        clear      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic sendFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        applyStimulus(1'b1, a, 1'b0);
        applyStimulus(1'b1, b, 1'b0);
        applyStimulus(1'b1, c, 1'b0);
        applyStimulus(1'b1, d, 1'b0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        clear       = 1'b0;
        prod_valid  = 1'b0;
        prod_in     = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset acc_out", 32'(acc_out), 32'd0);
        checkOutput("reset acc_valid", 32'(acc_valid), 32'd0);
        checkOutput("reset term_cnt", 32'(term_cnt), 32'd0);
        checkOutput("reset ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Test 1: basic frame 3,7,0,15
        applyStimulus(1'b1, 8'd3, 1'b0);
        checkOutput("t1 term_cnt after 1", 32'(term_cnt), 32'd1);
        applyStimulus(1'b1, 8'd7, 1'b0);
        checkOutput("t1 term_cnt after 2", 32'(term_cnt), 32'd2);
        applyStimulus(1'b1, 8'd0, 1'b0);
        checkOutput("t1 term_cnt after 3", 32'(term_cnt), 32'd3);
        checkOutput("t1 no early valid", 32'(acc_valid), 32'd0);
        applyStimulus(1'b1, 8'd15, 1'b0);
        checkOutput("t1 acc_valid", 32'(acc_valid), 32'd1);
        checkOutput("t1 acc_out", 32'(acc_out), 32'd25);
        checkOutput("t1 ovf", 32'(ovf), 32'd0);
        checkOutput("t1 in_ready in DONE", 32'(in_ready), 32'd0);
        checkOutput("t1 term_cnt in DONE", 32'(term_cnt), 32'd4);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t1 acc_valid drops", 32'(acc_valid), 32'd0);
        checkOutput("t1 term_cnt idle", 32'(term_cnt), 32'd0);
        checkOutput("t1 in_ready idle", 32'(in_ready), 32'd1);
        checkOutput("t1 acc_out holds", 32'(acc_out), 32'd25);

        // Test 2: 225 x4, wide and narrow accumulator, then 1 x4
        sendFrame(8'd225, 8'd225, 8'd225, 8'd225);
        checkOutput("t2 acc_out w10", 32'(acc_out), 32'd900);
        checkOutput("t2 ovf w10", 32'(ovf), 32'd0);
        checkOutput("t2 acc_out w8", 32'(acc_out8), 32'd132);
        checkOutput("t2 ovf w8", 32'(ovf8), 32'd1);
        checkOutput("t2 acc_valid w8", 32'(acc_valid8), 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t2 ovf w8 holds", 32'(ovf8), 32'd1);
        sendFrame(8'd1, 8'd1, 8'd1, 8'd1);
        checkOutput("t2 next acc_out w8", 32'(acc_out8), 32'd4);
        checkOutput("t2 next ovf w8", 32'(ovf8), 32'd0);
        checkOutput("t2 next acc_out w10", 32'(acc_out), 32'd4);
        applyStimulus(1'b0, 8'd0, 1'b0);

        // Test 3: gaps between terms
        applyStimulus(1'b1, 8'd5, 1'b0);
        checkOutput("t3 term 1", 32'(term_cnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'd99, 1'b0);
            checkOutput("t3 gap term holds", 32'(term_cnt), 32'd1);
            checkOutput("t3 gap no valid", 32'(acc_valid), 32'd0);
        end
        applyStimulus(1'b1, 8'd6, 1'b0);
        checkOutput("t3 term 2", 32'(term_cnt), 32'd2);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t3 gap2 term holds", 32'(term_cnt), 32'd2);
        applyStimulus(1'b1, 8'd7, 1'b0);
        checkOutput("t3 term 3", 32'(term_cnt), 32'd3);
        applyStimulus(1'b1, 8'd8, 1'b0);
        checkOutput("t3 term 4", 32'(term_cnt), 32'd4);
        checkOutput("t3 acc_out", 32'(acc_out), 32'd26);
        checkOutput("t3 acc_valid", 32'(acc_valid), 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t3 single pulse", 32'(acc_valid), 32'd0);

        // Test 4: back-to-back frames, 5 presented during DONE is held over
        sendFrame(8'd1, 8'd2, 8'd3, 8'd4);
        checkOutput("t4 first acc_out", 32'(acc_out), 32'd10);
        checkOutput("t4 in_ready low", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 8'd5, 1'b0);
        checkOutput("t4 5 not consumed", 32'(term_cnt), 32'd0);
        checkOutput("t4 no double valid", 32'(acc_valid), 32'd0);
        sendFrame(8'd5, 8'd6, 8'd7, 8'd8);
        checkOutput("t4 second acc_out", 32'(acc_out), 32'd26);
        checkOutput("t4 second valid", 32'(acc_valid), 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0);

        // Test 5: clear mid-frame drops the coincident product
        applyStimulus(1'b1, 8'd4, 1'b0);
        applyStimulus(1'b1, 8'd4, 1'b0);
        checkOutput("t5 term before clear", 32'(term_cnt), 32'd2);
        applyStimulus(1'b1, 8'd9, 1'b1);
        checkOutput("t5 term after clear", 32'(term_cnt), 32'd0);
        checkOutput("t5 acc_out kept", 32'(acc_out), 32'd26);
        checkOutput("t5 no valid", 32'(acc_valid), 32'd0);
        checkOutput("t5 in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("t5 9 dropped", 32'(term_cnt), 32'd0);
        sendFrame(8'd2, 8'd2, 8'd2, 8'd2);
        checkOutput("t5 acc_out", 32'(acc_out), 32'd8);
        applyStimulus(1'b0, 8'd0, 1'b0);

        // Test 6: asynchronous reset between edges
        applyStimulus(1'b1, 8'd1, 1'b0);
        applyStimulus(1'b1, 8'd2, 1'b0);
        checkOutput("t6 term before rst", 32'(term_cnt), 32'd2);
        prod_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6 async term_cnt", 32'(term_cnt), 32'd0);
        checkOutput("t6 async acc_out", 32'(acc_out), 32'd0);
        checkOutput("t6 async acc_valid", 32'(acc_valid), 32'd0);
        checkOutput("t6 async in_ready", 32'(in_ready), 32'd1);
        checkOutput("t6 async ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sendFrame(8'd1, 8'd2, 8'd3, 8'd4);
        checkOutput("t6 acc_out", 32'(acc_out), 32'd10);
        checkOutput("t6 acc_valid", 32'(acc_valid), 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
